// File: rtl/pio_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pio_access_arbiter
// Purpose : two-requester arbiter serialising accesses to an Avalon PIO slave
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module pio_access_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ack,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ack,
  output logic [31:0] req1_rdata,
  output logic        busy,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_write_q, cmd_write_d;
  logic [1:0]  cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        winner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= 2'd0;
      cmd_wdata_q  <= 32'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    winner       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Contention: round-robin favours whoever did not win last time
          if (req0_valid && req1_valid) begin
            winner = (FAIR != 0) ? ~last_grant_q : 1'b0;
          end else begin
            winner = req1_valid;
          end
          grant_d      = winner;
          last_grant_d = winner;
          cmd_write_d  = winner ? req1_write : req0_write;
          cmd_addr_d   = winner ? req1_addr  : req0_addr;
          cmd_wdata_d  = winner ? req1_wdata : req0_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (!cmd_write_q) begin
          if (grant_q) begin
            rdata1_d = pio_readdata;
          end else begin
            rdata0_d = pio_readdata;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs decode from state so an asynchronous reset clears them at once
  always_comb begin
    busy           = (state_q != IDLE);
    pio_chipselect = (state_q == ACCESS);
    pio_write_n    = !((state_q == ACCESS) && cmd_write_q);
    pio_address    = (state_q == ACCESS) ? cmd_addr_q  : 2'd0;
    pio_writedata  = (state_q == ACCESS) ? cmd_wdata_q : 32'd0;
    req0_ack       = (state_q == DONE) && !grant_q;
    req1_ack       = (state_q == DONE) &&  grant_q;
    req0_rdata     = rdata0_q;
    req1_rdata     = rdata1_q;
  end

endmodule
`default_nettype wire

// File: doc/pio_access_arbiter.md
PIO_ACCESS_ARBITER -- requirements
Module: pio_access_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 Signal clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 Signal reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Signals req0_valid and req1_valid, input, 1 bit each: access request; held high with stable fields until the matching ack.
REQ-005 Signals req0_write and req1_write, input, 1 bit each: 1 = write, 0 = read.
REQ-006 Signals req0_addr and req1_addr, input, 2 bits each: PIO register address.
REQ-007 Signals req0_wdata and req1_wdata, input, 32 bits each: write data.
REQ-008 Signals req0_ack and req1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-009 Signals req0_rdata and req1_rdata, output, 32 bits each: read result, registered, valid while the matching ack is high, held until that requester's next read completes.
REQ-010 Signal busy, output, 1 bit: high in every state other than IDLE.
REQ-011 Signal pio_address, output, 2 bits: address to the Avalon PIO slave.
REQ-012 Signal pio_chipselect, output, 1 bit: slave select.
REQ-013 Signal pio_write_n, output, 1 bit: active-low write strobe.
REQ-014 Signal pio_writedata, output, 32 bits: data to the slave.
REQ-015 Signal pio_readdata, input, 32 bits: combinational read data from the slave.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-017 In IDLE with any valid high, the FSM SHALL latch the winner's write, addr and wdata into a command register plus a grant index, then move to ACCESS.
REQ-018 In IDLE with no valid high, the FSM SHALL stay in IDLE.
REQ-019 ACCESS SHALL last exactly one cycle with pio_chipselect=1 and pio_address/pio_writedata driven from the command register.
REQ-020 In ACCESS, pio_write_n SHALL be 0 for writes and 1 for reads.
REQ-021 At the end of a read ACCESS, pio_readdata SHALL be captured into the granted requester's rdata register.
REQ-022 DONE SHALL pulse the granted requester's ack for one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-023 Outside ACCESS, outputs SHALL be pio_chipselect=0, pio_write_n=1, pio_address=0 and pio_writedata=0.
REQ-024 Latency: valid sampled in IDLE at edge k gives ACCESS in cycle k+1 and ack in cycle k+2; minimum request-to-request spacing is 3 cycles.
REQ-025 With FAIR=1 and both valid high, the grant SHALL go to the requester not recorded in last_grant.
REQ-026 last_grant SHALL update on every grant.
REQ-027 With FAIR=0 and both valid high, requester 0 SHALL always win.
REQ-028 A valid that drops after grant SHALL NOT abort the access; its ack SHALL still pulse.
REQ-029 The non-granted requester's ack and rdata SHALL be unaffected.
REQ-030 Addresses 1-3 SHALL be passed through unchanged; the slave ignores writes to them and returns 0 on reads.
REQ-031 A valid held high through its own ack SHALL be treated as a new request in the following IDLE.

Reset
REQ-032 Asserting reset_n=0 SHALL immediately force IDLE and clear all outputs to 0, except pio_write_n, which SHALL be 1.
REQ-033 Reset SHALL clear both rdata registers and the command register to 0.
REQ-034 Reset SHALL set last_grant=1, so requester 0 wins the first contest.
REQ-035 Reset during ACCESS or DONE SHALL drop the transaction with no ack and no slave write after release.

Verification
REQ-036 Reset check: reset_n low -> all outputs 0, pio_write_n=1, busy=0.
REQ-037 req0 writes addr 0, data 0xA5A5_0001 -> pio_chipselect high exactly 1 cycle with pio_write_n=0 and pio_writedata=0xA5A5_0001; req0_ack 2 cycles after sampling.
REQ-038 Then req1 reads addr 0 -> req1_rdata=0xA5A5_0001 with req1_ack; req0_rdata stays 0.
REQ-039 FAIR=1, both requesters request together from reset and keep re-requesting -> grants in order 0,1,0,1; each ack spaced 3 cycles apart.
REQ-040 FAIR=0, req0_valid held high continuously with req1 pending -> req1 is never acked while req0 stays high, and is served within 3 cycles of req0 dropping.
REQ-041 Reset asserted while pio_chipselect=1 -> chipselect drops the same cycle, no ack, and IDLE after release.
